// File: rtl/pong_pkg.sv
// Shared types, default field geometry and the paddle hit test for the pong ball engine.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE_WAIT = 2'd0,
        PLAY       = 2'd1,
        GAME_OVER  = 2'd2
    } state_t;

    typedef enum logic {
        POS = 1'b0,
        NEG = 1'b1
    } dir_t;

    localparam int DEF_FIELD_W  = 32;
    localparam int DEF_FIELD_H  = 24;
    localparam int DEF_PADDLE_H = 4;

    // A paddle spans py..py+paddle_h-1, clipped to the last row of the field.
    function automatic logic paddle_covers(input int py, input int y,
                                           input int paddle_h = DEF_PADDLE_H,
                                           input int field_h  = DEF_FIELD_H);
        int bot;
        bot = py + paddle_h - 1;
        if (bot > field_h - 1)
            bot = field_h - 1;
        return (y >= py) && (y <= bot);
    endfunction

endpackage

// File: rtl/pong_score_keeper.sv
// Both player scores, saturating at the winning score, plus point pulse and winner flag.
module pong_score_keeper #(
    parameter int WIN_SCORE = 5,
    parameter int SCORE_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_p1_miss,
    input  logic               i_p2_miss,
    input  logic               i_clear,
    output logic [SCORE_W-1:0] o_p1_score,
    output logic [SCORE_W-1:0] o_p2_score,
    output logic               o_point_pulse,
    output logic               o_winner,
    output logic               o_win_now
);

    localparam logic [SCORE_W-1:0] WIN    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] WIN_M1 = SCORE_W'(WIN_SCORE - 1);

    logic [SCORE_W-1:0] r_p1_score;
    logic [SCORE_W-1:0] r_p2_score;
    logic               r_point_pulse;
    logic               r_winner;
    logic               w_p1_wins;
    logic               w_p2_wins;

    // A miss by one player is a point for the other; flags the point that ends the game.
    assign w_p1_wins = i_p2_miss && (r_p1_score == WIN_M1);
    assign w_p2_wins = i_p1_miss && (r_p2_score == WIN_M1);
    assign o_win_now = w_p1_wins || w_p2_wins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_score    <= '0;
            r_p2_score    <= '0;
            r_point_pulse <= 1'b0;
            r_winner      <= 1'b0;
        end else begin
            r_point_pulse <= i_p1_miss || i_p2_miss;
            if (i_clear) begin
                r_p1_score <= '0;
                r_p2_score <= '0;
                r_winner   <= 1'b0;
            end else begin
                if (i_p2_miss && r_p1_score != WIN)
                    r_p1_score <= r_p1_score + SCORE_W'(1);
                if (i_p1_miss && r_p2_score != WIN)
                    r_p2_score <= r_p2_score + SCORE_W'(1);
                if (w_p1_wins)
                    r_winner <= 1'b0;
                else if (w_p2_wins)
                    r_winner <= 1'b1;
            end
        end
    end

    assign o_p1_score    = r_p1_score;
    assign o_p2_score    = r_p2_score;
    assign o_point_pulse = r_point_pulse;
    assign o_winner      = r_winner;

endmodule

// File: rtl/pong_ball_engine.sv
// Ball motion, wall/paddle bounces, miss detection and serve/play/game-over sequencing.
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int FIELD_W   = DEF_FIELD_W,
    parameter int FIELD_H   = DEF_FIELD_H,
    parameter int PADDLE_H  = DEF_PADDLE_H,
    parameter int WIN_SCORE = 5,
    parameter int SCORE_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       serve,
    input  logic [$clog2(FIELD_H)-1:0] p1_paddle_y,
    input  logic [$clog2(FIELD_H)-1:0] p2_paddle_y,
    output logic [$clog2(FIELD_W)-1:0] ball_x,
    output logic [$clog2(FIELD_H)-1:0] ball_y,
    output logic [SCORE_W-1:0]         p1_score,
    output logic [SCORE_W-1:0]         p2_score,
    output logic                       point_pulse,
    output logic                       game_over,
    output logic                       winner
);

    localparam int XW = $clog2(FIELD_W);
    localparam int YW = $clog2(FIELD_H);
    localparam logic [XW-1:0] X_CTR   = XW'(FIELD_W / 2);
    localparam logic [YW-1:0] Y_CTR   = YW'(FIELD_H / 2);
    localparam logic [XW-1:0] X_LAST  = XW'(FIELD_W - 1);
    localparam logic [XW-1:0] X_P2HIT = XW'(FIELD_W - 2);
    localparam logic [XW-1:0] X_P2RET = XW'(FIELD_W - 3);
    localparam logic [YW-1:0] Y_LAST  = YW'(FIELD_H - 1);
    localparam logic [YW-1:0] Y_LAST1 = YW'(FIELD_H - 2);

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    dir_t          r_dx;
    dir_t          r_dy;
    dir_t          r_serve_dy;

    logic [XW-1:0] w_x_next;
    logic [YW-1:0] w_y_next;
    dir_t          w_dx_next;
    dir_t          w_dy_next;
    logic          w_miss1;
    logic          w_miss2;
    logic          w_step;
    logic          w_win_now;
    logic          w_clear;

    // Vertical move first; the paddle test then uses the row the ball is moving into.
    always_comb begin
        w_dy_next = r_dy;
        w_y_next  = r_y;
        w_dx_next = r_dx;
        w_x_next  = r_x;
        w_miss1   = 1'b0;
        w_miss2   = 1'b0;
        if (r_y == '0 && r_dy == NEG) begin
            w_dy_next = POS;
            w_y_next  = YW'(1);
        end else if (r_y == Y_LAST && r_dy == POS) begin
            w_dy_next = NEG;
            w_y_next  = Y_LAST1;
        end else if (r_dy == POS) begin
            w_y_next = r_y + YW'(1);
        end else begin
            w_y_next = r_y - YW'(1);
        end

        if (r_x == XW'(1) && r_dx == NEG) begin
            if (paddle_covers(int'(p1_paddle_y), int'(w_y_next), PADDLE_H, FIELD_H)) begin
                w_dx_next = POS;
                w_x_next  = XW'(2);
            end else begin
                w_x_next = '0;
                w_miss1  = 1'b1;
            end
        end else if (r_x == X_P2HIT && r_dx == POS) begin
            if (paddle_covers(int'(p2_paddle_y), int'(w_y_next), PADDLE_H, FIELD_H)) begin
                w_dx_next = NEG;
                w_x_next  = X_P2RET;
            end else begin
                w_x_next = X_LAST;
                w_miss2  = 1'b1;
            end
        end else if (r_dx == POS) begin
            w_x_next = r_x + XW'(1);
        end else begin
            w_x_next = r_x - XW'(1);
        end
    end

    assign w_step  = (r_state == PLAY) && tick;
    assign w_clear = (r_state == GAME_OVER) && serve;

    pong_score_keeper #(
        .WIN_SCORE (WIN_SCORE),
        .SCORE_W   (SCORE_W)
    ) u_score (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_p1_miss     (w_step && w_miss1),
        .i_p2_miss     (w_step && w_miss2),
        .i_clear       (w_clear),
        .o_p1_score    (p1_score),
        .o_p2_score    (p2_score),
        .o_point_pulse (point_pulse),
        .o_winner      (winner),
        .o_win_now     (w_win_now)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SERVE_WAIT;
            r_x        <= X_CTR;
            r_y        <= Y_CTR;
            r_dx       <= POS;
            r_dy       <= POS;
            r_serve_dy <= POS;
        end else begin
            case (r_state)
                SERVE_WAIT: begin
                    r_x <= X_CTR;
                    r_y <= Y_CTR;
                    if (serve)
                        r_state <= PLAY;
                end
                PLAY: begin
                    if (tick) begin
                        r_x <= w_x_next;
                        r_y <= w_y_next;
                        if (w_miss1 || w_miss2) begin
                            if (w_win_now) begin
                                r_state <= GAME_OVER;
                            end else begin
                                // Next serve heads toward whoever missed, alternating vertical direction.
                                r_state    <= SERVE_WAIT;
                                r_dx       <= w_miss1 ? NEG : POS;
                                r_dy       <= dir_t'(~r_serve_dy);
                                r_serve_dy <= dir_t'(~r_serve_dy);
                            end
                        end else begin
                            r_dx <= w_dx_next;
                            r_dy <= w_dy_next;
                        end
                    end
                end
                GAME_OVER: begin
                    if (serve) begin
                        r_state    <= SERVE_WAIT;
                        r_x        <= X_CTR;
                        r_y        <= Y_CTR;
                        r_dx       <= POS;
                        r_dy       <= POS;
                        r_serve_dy <= POS;
                    end
                end
                default: r_state <= SERVE_WAIT;
            endcase
        end
    end

    assign ball_x    = r_x;
    assign ball_y    = r_y;
    assign game_over = (r_state == GAME_OVER);

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine with hand-computed ball positions and scores.
module tb_pong_ball_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       serve;
    logic [4:0] p1_paddle_y;
    logic [4:0] p2_paddle_y;
    logic [4:0] ball_x;
    logic [4:0] ball_y;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       point_pulse;
    logic       game_over;
    logic       winner;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pong_ball_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .serve       (serve),
        .p1_paddle_y (p1_paddle_y),
        .p2_paddle_y (p2_paddle_y),
        .ball_x      (ball_x),
        .ball_y      (ball_y),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .point_pulse (point_pulse),
        .game_over   (game_over),
        .winner      (winner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, ".x"}, 32'(ball_x), 32'(x));
        chk({tag, ".y"}, 32'(ball_y), 32'(y));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic do_serve(input logic with_tick);
        @(negedge clk);
        serve = 1'b1;
        tick  = with_tick;
        @(negedge clk);
        serve = 1'b0;
        tick  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; serve = 1'b0;
        p1_paddle_y = 5'd0; p2_paddle_y = 5'd16;
        #12;
        chk_ball("rst", 16, 12);
        chk("rst.p1", 32'(p1_score), 0);
        chk("rst.p2", 32'(p2_score), 0);
        chk("rst.pp", 32'(point_pulse), 0);
        chk("rst.go", 32'(game_over), 0);
        chk("rst.win", 32'(winner), 0);
        @(negedge clk) rst_n = 1'b1;

        step(1);
        chk_ball("wait_tick", 16, 12);
        do_serve(1'b1);
        chk_ball("serve_tick", 16, 12);
        step(3);
        chk_ball("three", 19, 15);
        chk("three.pp", 32'(point_pulse), 0);
        chk("three.p1", 32'(p1_score), 0);

        step(8);
        chk_ball("bottom", 27, 23);
        step(1);
        chk_ball("bounce_bot", 28, 22);
        step(3);
        chk_ball("p2_hit", 29, 19);
        step(19);
        chk_ball("top", 10, 0);
        step(1);
        chk_ball("bounce_top", 9, 1);
        step(8);
        chk_ball("near_p1", 1, 9);
        p1_paddle_y = 5'd9;
        step(1);
        chk_ball("p1_hit", 2, 10);
        chk("p1_hit.p2", 32'(p2_score), 0);
        step(1);
        chk_ball("after_p1", 3, 11);

        p2_paddle_y = 5'd15;
        step(27);
        chk_ball("pre_miss2", 30, 8);
        step(1);
        chk_ball("miss2", 31, 7);
        chk("miss2.p1", 32'(p1_score), 1);
        chk("miss2.pp", 32'(point_pulse), 1);
        @(negedge clk);
        chk("miss2.pp_end", 32'(point_pulse), 0);
        chk_ball("recentre", 16, 12);
        chk("miss2.go", 32'(game_over), 0);

        do_serve(1'b0);
        do_serve(1'b1);
        chk_ball("play_serve_tick", 17, 11);
        step(1);
        chk_ball("still_play", 18, 10);

        p2_paddle_y = 5'd8;
        step(13);
        chk_ball("miss2b", 31, 3);
        chk("miss2b.p1", 32'(p1_score), 2);
        do_serve(1'b0);
        step(15);
        chk_ball("miss2c", 31, 19);
        chk("miss2c.p1", 32'(p1_score), 3);
        do_serve(1'b0);
        step(15);
        chk_ball("miss2d", 31, 3);
        chk("miss2d.p1", 32'(p1_score), 4);
        do_serve(1'b0);
        step(15);
        chk_ball("win", 31, 19);
        chk("win.p1", 32'(p1_score), 5);
        chk("win.pp", 32'(point_pulse), 1);
        chk("win.go", 32'(game_over), 1);
        chk("win.winner", 32'(winner), 0);

        @(negedge clk);
        step(2);
        chk_ball("go_tick", 31, 19);
        chk("go_tick.p1", 32'(p1_score), 5);
        chk("go_tick.go", 32'(game_over), 1);
        do_serve(1'b0);
        chk("restart.p1", 32'(p1_score), 0);
        chk("restart.go", 32'(game_over), 0);
        chk("restart.winner", 32'(winner), 0);
        chk_ball("restart", 16, 12);
        step(1);
        chk_ball("restart_wait", 16, 12);

        p1_paddle_y = 5'd0;
        p2_paddle_y = 5'd16;
        do_serve(1'b0);
        step(15);
        chk_ball("g2_p2_hit", 29, 19);
        step(28);
        chk_ball("g2_near_p1", 1, 9);
        step(1);
        chk_ball("miss1", 0, 10);
        chk("miss1.p2", 32'(p2_score), 1);
        chk("miss1.p1", 32'(p1_score), 0);
        chk("miss1.pp", 32'(point_pulse), 1);
        do_serve(1'b0);
        step(1);
        chk_ball("serve_to_p1", 15, 11);

        #2 rst_n = 1'b0;
        #1;
        chk_ball("async_rst", 16, 12);
        chk("async_rst.p2", 32'(p2_score), 0);
        chk("async_rst.go", 32'(game_over), 0);
        @(negedge clk) rst_n = 1'b1;
        do_serve(1'b0);
        step(1);
        chk_ball("post_rst", 17, 13);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
